// File: rtl/and_share_arbiter.sv
// and_share_arbiter
//   Two requesters share one registered bitwise-AND unit. A single result
//   register (IDLE = empty, HOLD = full) is refilled in the same cycle that it
//   is drained, so back-to-back operation has no bubble. Ties alternate,
//   starting with requester 0 after reset.
// Ports
//   clk, rst_n               clock, async active-low reset
//   reqN_valid/a/b/ready     requester N (N = 0,1) operand handshake
//   res_valid/data/id/ready  registered result and owner index
//   done_count               results consumed, wraps modulo 2^CNT_W
module and_share_arbiter #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_data,
    output logic             res_id,
    input  logic             res_ready,
    output logic [CNT_W-1:0] done_count
);

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t                  state, state_nxt;
    logic                    last_grant;
    logic                    accept_ok;
    logic                    xfer;
    logic                    gidx;
    logic [1:0]              valid, gnt, ready;
    logic [1:0][WIDTH-1:0]   op_a, op_b;

    assign valid = {req1_valid, req0_valid};
    assign op_a  = {req1_a, req0_a};
    assign op_b  = {req1_b, req0_b};

    // Result slot can take new operands when empty or being drained now.
    assign accept_ok = (state == IDLE) || (res_ready && state == HOLD);

    // Tie goes to whoever did not win the last transfer.
    always_comb begin
        gnt = valid;
        if (valid == 2'b11)
            gnt = last_grant ? 2'b01 : 2'b10;
    end

    // Gated by rst_n so readys are low throughout reset, not just after it.
    assign ready      = (rst_n && accept_ok) ? gnt : 2'b00;
    assign req0_ready = ready[0];
    assign req1_ready = ready[1];
    assign xfer       = |ready;
    assign gidx       = ready[1];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (xfer) state_nxt = HOLD;
            HOLD:    if (res_ready && !xfer) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_data   <= '0;
            res_id     <= 1'b0;
            last_grant <= 1'b1;
        end else if (xfer) begin
            res_data   <= op_a[gidx] & op_b[gidx];
            res_id     <= gidx;
            last_grant <= gidx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     done_count <= '0;
        else if (res_valid && res_ready) done_count <= done_count + 1'b1;
    end

    assign res_valid = (state == HOLD);

    a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0({req1_ready, req0_ready}));

endmodule

// File: tb/tb_and_share_arbiter.sv
// Scoreboard bench for and_share_arbiter: the stimulus process predicts each
// grant and pushes {id,data}; the monitor pops on every consumed result.
module tb_and_share_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req1_valid, req0_ready, req1_ready;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic       res_valid, res_id, res_ready;
    logic [3:0] res_data;
    logic [7:0] done_count;

    int n_checks = 0;
    int n_fail   = 0;
    logic [4:0] sb[$];

    always #5 clk = ~clk;

    and_share_arbiter #(.WIDTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .res_valid(res_valid), .res_data(res_data), .res_id(res_id), .res_ready(res_ready),
        .done_count(done_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive, check readys/res_valid at negedge, predict result.
    task automatic cyc(input logic v0, input logic [3:0] a0, input logic [3:0] b0,
                       input logic v1, input logic [3:0] a1, input logic [3:0] b1,
                       input logic rr, input logic e_r0, input logic e_r1,
                       input logic e_rv, input logic [3:0] e_d);
        req0_valid = v0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_a = a1; req1_b = b1;
        res_ready  = rr;
        @(negedge clk);
        chk("req0_ready", req0_ready, e_r0);
        chk("req1_ready", req1_ready, e_r1);
        chk("res_valid", res_valid, e_rv);
        if (e_r0) sb.push_back({1'b0, e_d});
        if (e_r1) sb.push_back({1'b1, e_d});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b0;
        #2;
        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_res_data", res_data, 4'h0);
        chk("rst_res_id", res_id, 1'b0);
        chk("rst_done_count", done_count, 8'd0);
        chk("rst_readys", {req1_ready, req0_ready}, 2'b00);
        sb.delete();
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: every consumed result must match the oldest prediction.
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            logic [4:0] e;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_empty: got id=%0d data=%0h expected none", res_id, res_data);
            end else begin
                e = sb.pop_front();
                chk("res_data", res_data, e[3:0]);
                chk("res_id", res_id, e[4]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        req0_a = 4'h0; req0_b = 4'h0; req1_a = 4'h0; req1_b = 4'h0;
        do_reset();

        // Single request: C & A = 8, consumed next cycle.
        cyc(1, 4'hC, 4'hA, 0, 4'h0, 4'h0, 1, 1, 0, 0, 4'h8);
        cyc(0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 1, 0, 0, 1, 4'h0);
        chk("done_after_single", done_count, 8'd1);

        // Tie after reset alternates 0,1,0,1 with no bubble.
        do_reset();
        cyc(1, 4'hF, 4'h3, 1, 4'hF, 4'h5, 1, 1, 0, 0, 4'h3);
        cyc(1, 4'hF, 4'h3, 1, 4'hF, 4'h5, 1, 0, 1, 1, 4'h5);
        cyc(1, 4'hF, 4'h3, 1, 4'hF, 4'h5, 1, 1, 0, 1, 4'h3);
        cyc(1, 4'hF, 4'h3, 1, 4'hF, 4'h5, 1, 0, 1, 1, 4'h5);
        cyc(0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 1, 0, 0, 1, 4'h0);
        chk("done_after_tie", done_count, 8'd4);

        // Backpressure: 6&7=6 held three cycles while req1 waits.
        cyc(1, 4'h6, 4'h7, 0, 4'h0, 4'h0, 0, 1, 0, 0, 4'h6);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 4'h0, 4'h0, 1, 4'h3, 4'h2, 0, 0, 0, 1, 4'h0);
            chk("bp_data_stable", res_data, 4'h6);
        end
        cyc(0, 4'h0, 4'h0, 1, 4'h3, 4'h2, 1, 0, 1, 1, 4'h2);
        cyc(0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 1, 0, 0, 1, 4'h0);
        chk("done_after_bp", done_count, 8'd6);

        // Reset while holding 9: discarded, then tie goes to req0.
        cyc(1, 4'h9, 4'hF, 0, 4'h0, 4'h0, 0, 1, 0, 0, 4'h9);
        chk("hold_data_9", res_data, 4'h9);
        do_reset();
        cyc(1, 4'hF, 4'h3, 1, 4'hF, 4'h5, 1, 1, 0, 0, 4'h3);
        cyc(0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 1, 0, 0, 1, 4'h0);
        chk("done_after_rst", done_count, 8'd1);

        // Counter wrap: 256 consumed results.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            logic [3:0] a;
            a = i[3:0];
            cyc(1, a, 4'hF, 0, 4'h0, 4'h0, 1, 1, 0, (i != 0), a);
        end
        chk("done_255", done_count, 8'd255);
        cyc(0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 1, 0, 0, 1, 4'h0);
        chk("done_wrap", done_count, 8'd0);

        cyc(0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 1, 0, 0, 0, 4'h0);
        chk("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/and_share_arbiter.md
AND_SHARE_ARBITER -- requirements
Module: and_share_arbiter

Interface
REQ-001 Parameter: WIDTH, 4, operand and result width in bits.
REQ-002 Parameter: CNT_W, 8, width of the completed-operation counter.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port: req0_valid  input  1  requester 0 has an operand pair.
REQ-006 Port: req0_a, req0_b  input  WIDTH  requester 0 operands.
REQ-007 Port: req0_ready  output  1  requester 0 operands accepted this cycle.
REQ-008 Port: req1_valid  input  1  requester 1 has an operand pair.
REQ-009 Port: req1_a, req1_b  input  WIDTH  requester 1 operands.
REQ-010 Port: req1_ready  output  1  requester 1 operands accepted this cycle.
REQ-011 Port: res_valid  output  1  result register holds an unconsumed result.
REQ-012 Port: res_data  output  WIDTH  registered bitwise AND of the granted operands.
REQ-013 Port: res_id  output  1  index of the requester that owns res_data.
REQ-014 Port: res_ready  input  1  consumer takes the result this cycle.
REQ-015 Port: done_count  output  CNT_W  number of results consumed, modulo 2^CNT_W.

Function
REQ-016 The block SHALL implement two states: IDLE (result register empty) and HOLD (result register full).
REQ-017 The block SHALL derive accept_ok = (state==IDLE) | (state==HOLD & res_ready).
REQ-018 The block SHALL assert at most one of req0_ready and req1_ready per cycle, and only when accept_ok is 1 and the matching valid is 1.
REQ-019 Grant rule: if only one requester is valid, grant that requester; if both are valid, grant the requester that is not last_grant.
REQ-020 The block SHALL update last_grant to the granted index only on a cycle where a transfer occurs (valid & ready).
REQ-021 On a transfer, the block SHALL load res_data <= a & b of the granted requester and res_id <= the granted index on the same edge, for a latency of 1 cycle from accept to res_valid.
REQ-022 IDLE -> HOLD on a transfer; IDLE stays IDLE otherwise.
REQ-023 HOLD with res_ready=0: the block SHALL stay in HOLD, hold res_data and res_id stable, and deassert both readys.
REQ-024 HOLD with res_ready=1 and a transfer: the block SHALL stay in HOLD and load the new result (back-to-back, no bubble).
REQ-025 HOLD with res_ready=1 and no transfer: HOLD -> IDLE.
REQ-026 res_valid SHALL equal (state==HOLD).
REQ-027 done_count SHALL increment by 1 on every cycle with res_valid & res_ready, and SHALL wrap from 2^CNT_W-1 to 0.
REQ-028 The readys SHALL be combinational in the valids, state and res_ready; the result outputs SHALL be registered only.
REQ-029 Operand changes while valid=0 or ready=0 SHALL have no effect on state.

Reset
REQ-030 While rst_n=0, regardless of clk: state=IDLE, res_valid=0, res_data=0, res_id=0, done_count=0, last_grant=1 (requester 0 wins the first tie).
REQ-031 Both readys SHALL be 0 while rst_n=0.
REQ-032 Assertion of rst_n mid-HOLD SHALL discard the pending result immediately, with no res_valid pulse after release.
REQ-033 After rst_n rises, the first transfer SHALL take effect on the first rising clk edge.

Verification
REQ-034 Single request: req0 a=4'b1100, b=4'b1010, res_ready=1 -> req0_ready=1 in cycle 0; cycle 1 res_valid=1, res_data=4'b1000, res_id=0; done_count=1 after cycle 1.
REQ-035 Tie after reset: both valid, req0 a=F b=3, req1 a=F b=5, res_ready=1 held -> grants req0, then req1, alternating; res_data sequence 3,5,3,5 with no idle cycles.
REQ-036 Backpressure: result pending with res_ready=0 for 3 cycles and req1_valid=1 -> both readys 0 and res_data stable; on res_ready=1, req1 accepted in the same cycle.
REQ-037 Reset mid-operation: rst_n pulsed low in HOLD with res_data=4'h9 -> res_valid=0, res_data=0 and done_count=0 asynchronously; next tie goes to req0.
REQ-038 Counter wrap: with CNT_W=8, 256 consumed results -> done_count returns to 0.
REQ-039 Formal properties: readys are one-hot-or-zero; res_data stays stable while res_valid & !res_ready; res_data == captured a & b.
